// File: rtl/gsu_pkg.sv
// gsu_pkg: GSU code-cache geometry and fill-engine state encoding shared with the core's cache decode
package gsu_pkg;
  localparam int LINE_BYTES = 16;
  localparam int LINES = 32;
  localparam int CACHE_BYTES = LINE_BYTES * LINES;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WR,
    ST_DONE,
    ST_FIN,
    ST_BYP,
    ST_BYPOUT
  } fill_state_e;
  function automatic logic [15:0] win_off(input logic [15:0] pc, input logic [15:0] base);
    return pc - base;
  endfunction
endpackage

// File: rtl/gsu_cache_flags.sv
// gsu_cache_flags: per-line valid flags; a clear-all in the same cycle as any set wins
module gsu_cache_flags #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [N-1:0] set_mask,
  output logic [N-1:0] flags
);
  logic [N-1:0] flags_q, flags_d;
  always_comb flags_d = clr ? '0 : flags_q | set_mask;
  always_ff @(posedge clk) begin
    if (rst) flags_q <= '0;
    else flags_q <= flags_d;
  end
  assign flags = flags_q;
endmodule

// File: rtl/gsu_cache_fill.sv
// gsu_cache_fill: line fill and out-of-window bypass fetch engine for the GSU code cache
module gsu_cache_fill #(
  parameter int LINE_BYTES = gsu_pkg::LINE_BYTES,
  parameter int LINES = gsu_pkg::LINES
) (
  input  logic                                     clkin,
  input  logic                                     rst,
  input  logic                                     miss_req,
  input  logic [15:0]                              miss_pc,
  input  logic [7:0]                               pbr,
  input  logic [15:0]                              cbr,
  input  logic                                     flush,
  input  logic                                     snes_line_set,
  input  logic [$clog2(LINES)-1:0]                 snes_line_idx,
  output logic                                     mem_rrq,
  output logic [23:0]                              mem_addr,
  input  logic                                     mem_rdy,
  input  logic [7:0]                               mem_data,
  output logic                                     cw_en,
  output logic [$clog2(LINES*LINE_BYTES)-1:0]      cw_addr,
  output logic [7:0]                               cw_data,
  output logic [LINES-1:0]                         line_valid,
  output logic                                     busy,
  output logic                                     fill_done,
  output logic                                     bypass_valid,
  output logic [7:0]                               bypass_data
);
  import gsu_pkg::*;
  localparam int OW = $clog2(LINE_BYTES);
  localparam int LW = $clog2(LINES);
  localparam int AW = OW + LW;
  fill_state_e state_q, state_d;
  logic [OW-1:0] cnt_q, cnt_d;
  logic [15-OW:0] tag_q, tag_d;
  logic [7:0] pbr_q, pbr_d;
  logic [LW-1:0] line_q, line_d;
  logic abort_q, abort_d;
  logic mem_rrq_q, mem_rrq_d;
  logic [23:0] mem_addr_q, mem_addr_d;
  logic cw_en_q, cw_en_d;
  logic [AW-1:0] cw_addr_q, cw_addr_d;
  logic [7:0] cw_data_q, cw_data_d;
  logic busy_q, busy_d;
  logic fill_done_q, fill_done_d;
  logic bypass_valid_q, bypass_valid_d;
  logic [7:0] bypass_data_q, bypass_data_d;
  logic [15:0] off;
  logic in_win, fill_set;
  logic [LINES-1:0] set_mask;
  assign off = win_off(miss_pc, cbr);
  assign in_win = off < 16'(LINES * LINE_BYTES);
  assign fill_set = (state_q == ST_DONE) && !flush;
  assign set_mask = ({{(LINES-1){1'b0}}, fill_set} << line_q)
                  | ({{(LINES-1){1'b0}}, snes_line_set} << snes_line_idx);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    tag_d = tag_q;
    pbr_d = pbr_q;
    line_d = line_q;
    abort_d = abort_q | (flush && state_q == ST_REQ);
    mem_rrq_d = mem_rrq_q;
    mem_addr_d = mem_addr_q;
    cw_en_d = 1'b0;
    cw_addr_d = cw_addr_q;
    cw_data_d = cw_data_q;
    busy_d = busy_q;
    fill_done_d = 1'b0;
    bypass_valid_d = 1'b0;
    bypass_data_d = bypass_data_q;
    case (state_q)
      ST_IDLE: if (miss_req) begin
        tag_d = miss_pc[15:OW];
        pbr_d = pbr;
        line_d = off[AW-1:OW];
        cnt_d = '0;
        abort_d = 1'b0;
        busy_d = 1'b1;
        mem_rrq_d = 1'b1;
        state_d = in_win ? ST_REQ : ST_BYP;
        mem_addr_d = in_win ? {pbr, miss_pc[15:OW], {OW{1'b0}}} : {pbr, miss_pc};
      end
      // an aborted fill still waits out its outstanding read, then drops the byte
      ST_REQ: if (mem_rdy) begin
        mem_rrq_d = 1'b0;
        state_d = abort_d ? ST_IDLE : ST_WR;
        busy_d = !abort_d;
        cw_en_d = !abort_d;
        cw_addr_d = {line_q, cnt_q};
        cw_data_d = mem_data;
      end
      ST_WR: begin
        if (flush) begin
          state_d = ST_IDLE;
          busy_d = 1'b0;
        end else if (cnt_q == '1) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          state_d = ST_REQ;
          mem_rrq_d = 1'b1;
          mem_addr_d = {pbr_q, tag_q, cnt_d};
        end
      end
      ST_DONE: begin
        state_d = flush ? ST_IDLE : ST_FIN;
        busy_d = !flush;
        fill_done_d = !flush;
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        busy_d = 1'b0;
      end
      ST_BYP: if (mem_rdy) begin
        mem_rrq_d = 1'b0;
        bypass_data_d = mem_data;
        state_d = ST_BYPOUT;
      end
      ST_BYPOUT: begin
        bypass_valid_d = 1'b1;
        state_d = ST_FIN;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d = 1'b0;
        mem_rrq_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clkin) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      tag_q <= '0;
      pbr_q <= '0;
      line_q <= '0;
      abort_q <= 1'b0;
      mem_rrq_q <= 1'b0;
      mem_addr_q <= '0;
      cw_en_q <= 1'b0;
      cw_addr_q <= '0;
      cw_data_q <= '0;
      busy_q <= 1'b0;
      fill_done_q <= 1'b0;
      bypass_valid_q <= 1'b0;
      bypass_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      tag_q <= tag_d;
      pbr_q <= pbr_d;
      line_q <= line_d;
      abort_q <= abort_d;
      mem_rrq_q <= mem_rrq_d;
      mem_addr_q <= mem_addr_d;
      cw_en_q <= cw_en_d;
      cw_addr_q <= cw_addr_d;
      cw_data_q <= cw_data_d;
      busy_q <= busy_d;
      fill_done_q <= fill_done_d;
      bypass_valid_q <= bypass_valid_d;
      bypass_data_q <= bypass_data_d;
    end
  end
  gsu_cache_flags #(.N(LINES)) u_flags (
    .clk(clkin),
    .rst(rst),
    .clr(flush),
    .set_mask(set_mask),
    .flags(line_valid)
  );
  assign mem_rrq = mem_rrq_q;
  assign mem_addr = mem_addr_q;
  assign cw_en = cw_en_q;
  assign cw_addr = cw_addr_q;
  assign cw_data = cw_data_q;
  assign busy = busy_q;
  assign fill_done = fill_done_q;
  assign bypass_valid = bypass_valid_q;
  assign bypass_data = bypass_data_q;
endmodule

// File: doc/gsu_cache_fill.md
# gsu_cache_fill

Upstream instruction-cache fill engine for the GSU core. It owns the 32 line-valid flags of the 512-byte GSU code cache. On a core miss it fetches a whole 16-byte line from the Game Pak bus and writes it into the cache RAM through a byte write port. It also serves single-byte bypass fetches for code outside the cache window, and it applies flushes and SNES-side line loads.

## Interface
Parameters:
- LINE_BYTES, 16, bytes per cache line (power of two)
- LINES, 32, number of cache lines; LINES*LINE_BYTES = 512

Ports:
- clkin  in  1  system clock
- rst  in  1  synchronous, active-high reset
- miss_req  in  1  core requests the line containing miss_pc; level, held until fill_done or bypass_valid
- miss_pc  in  16  GSU program counter of the missing byte
- pbr  in  8  program bank register
- cbr  in  16  cache base register; bits [3:0] are zero
- flush  in  1  one-cycle pulse: clear all line flags (CACHE/LJMP, CBR change, G falling)
- snes_line_set  in  1  SNES wrote the last byte of a cache line
- snes_line_idx  in  5  line index for snes_line_set
- mem_rrq  out  1  Game Pak read request
- mem_addr  out  24  Game Pak byte address
- mem_rdy  in  1  read complete; mem_data is valid in the same cycle
- mem_data  in  8  read data
- cw_en  out  1  cache RAM write strobe
- cw_addr  out  9  cache RAM byte address
- cw_data  out  8  cache RAM write data
- line_valid  out  32  per-line valid flags, indexed by line
- busy  out  1  fill or bypass in progress
- fill_done  out  1  one-cycle pulse: the line is valid
- bypass_valid  out  1  one-cycle pulse: bypass_data is valid
- bypass_data  out  8  byte fetched for an out-of-window miss

## Operation
- Window offset: off = miss_pc − cbr, 16-bit and modulo 2^16. The address is in the window when off < 512. Line index = off[8:4].
- States and transitions:
  - IDLE: on miss_req, latch miss_pc, pbr and off. Go to FILL if in window, otherwise BYPASS.
  - FILL: byte counter cnt runs from 0 to 15. Each byte follows REQ → WAIT → WR. mem_addr = {pbr, miss_pc[15:4], cnt}. In WR: cw_en=1, cw_addr = {line, cnt}, cw_data = the captured byte. After cnt=15, go to DONE.
  - DONE: set line_valid[line], pulse fill_done, return to IDLE.
  - BYPASS: one read at {pbr, miss_pc}. Pulse bypass_valid with bypass_data. Flags and cache RAM are not touched. Return to IDLE.
- Memory handshake: mem_rrq is high from REQ until mem_rdy is sampled high, and falls in the next cycle. mem_addr is stable while mem_rrq is high. mem_rdy is ignored while mem_rrq is low.
- Line order is always byte 0 to byte 15 (no critical-word-first). The fill writes all 16 bytes even if some are already present.
- Flush: clears all 32 flags in the next cycle.
  - If a fill is in progress, the fill is aborted. An outstanding read runs to mem_rdy, its data is discarded, no further cw_en is issued, and the state returns to IDLE without fill_done.
  - The core re-requests after the abort.
- Flush and fill-completion in the same cycle: flush wins, so the line stays invalid and fill_done is suppressed.
- snes_line_set sets line_valid[snes_line_idx] in any state. If it occurs in the same cycle as flush, flush wins.
- If miss_req drops mid-fill, the fill still completes.

## Timing
- Reset values: all flags 0, state IDLE, mem_rrq 0, mem_addr 0, cw_en 0, cw_addr 0, cw_data 0, busy 0, fill_done 0, bypass_valid 0, bypass_data 0.
- Reset mid-fill: all outputs return to their reset values at the next edge. Any pending mem_rdy is ignored.
- miss_req is sampled in IDLE. busy and mem_rrq rise on the following edge.
- Per byte: with mem_rdy returning W cycles after mem_rrq rises, each byte costs W+2 cycles. A full line therefore costs 16·(W+2)+1 cycles from the first mem_rrq to fill_done.
- cw_en is registered and is high for exactly one cycle per byte.
- line_valid updates on the same edge that fill_done rises, so the core sees the flag together with the pulse.
- bypass_valid rises one cycle after the mem_rdy capture.
- busy falls in the cycle after fill_done or bypass_valid.

## Structure
- Shared package gsu_pkg holds the state encoding and the constants LINE_BYTES, LINES and CACHE_BYTES=512. The core's cache decode uses the same constants.
- One sub-module, gsu_cache_flags: the 32-bit flag register with set, clear-all and priority logic (flush > set).
- The FSM, byte counter and memory interface live in the top module.

## Test plan
- Fill in window: cbr=0x0000, pbr=0x01, miss_pc=0x0123, W=2.
  - mem_addr is 0x010120..0x01012F.
  - Sixteen cw_en pulses at cw_addr 0x120..0x12F carry the returned bytes.
  - fill_done after 65 cycles from the first mem_rrq; line_valid = 0x0004_0000.
- Bypass: cbr=0x8000, miss_pc=0x0010. One read at {pbr,0x0010}, bypass_valid with the data, no cw_en, line_valid unchanged.
- Window wrap: cbr=0xFF00, miss_pc=0x0050. off=0x0150, so the fill goes to line 21 and cw_addr 0x150..0x15F.
- Flush mid-fill at byte 7:
  - The outstanding read completes and no cw_en follows.
  - fill_done is never asserted.
  - line_valid = 0, and busy falls within 2 cycles of that mem_rdy.
- Flush in the cycle of the last WR (fill-completion) plus a simultaneous snes_line_set to line 3: line_valid = 0 and no fill_done.
- Reset during WAIT: mem_rrq=0 and busy=0 at the next edge. A late mem_rdy produces no cw_en. A new miss afterwards fills normally.
